// File: rtl/filtro_mac.sv
// filtro_mac: sequencer and multiply-accumulate stage of the FILTRO datapath.
// On an accepted start it steps mux_in's select through six operand codes,
// accumulates in*k[step] for each, then rescales (floor) and registers y with
// a one-cycle done pulse.
// Build option: define FILTRO_SAT_EN to clamp y to the signed output range and
// flag ovf; without it y is the wrapped low cant_bits of the rescaled sum and
// ovf is tied low.
module filtro_mac #(
    parameter int cant_bits = 25,
    parameter int frac_bits = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic signed [cant_bits-1:0] k0,
    input  logic signed [cant_bits-1:0] k1,
    input  logic signed [cant_bits-1:0] k2,
    input  logic signed [cant_bits-1:0] k3,
    input  logic signed [cant_bits-1:0] k4,
    input  logic signed [cant_bits-1:0] k5,
    input  logic signed [cant_bits-1:0] in,
    output logic [3:0]                  selec,
    output logic signed [cant_bits-1:0] y,
    output logic                        done,
    output logic                        busy,
    output logic                        ovf
);

    localparam int PROD_W = 2 * cant_bits;
    localparam int ACC_W  = 2 * cant_bits + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        SAT  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [2:0]                  step_q, step_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [cant_bits-1:0] y_q, y_d;
    logic                        done_q, done_d;
    logic signed [cant_bits-1:0] k_q [6];
    logic signed [cant_bits-1:0] k_d [6];

    logic signed [cant_bits-1:0] k_sel;
    logic signed [PROD_W-1:0]    in_ext, k_ext, prod;
    logic signed [ACC_W-1:0]     prod_ext;

`ifdef FILTRO_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX =
        {{(ACC_W-cant_bits+1){1'b0}}, {(cant_bits-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN =
        {{(ACC_W-cant_bits+1){1'b1}}, {(cant_bits-1){1'b0}}};

    logic                    ovf_q, ovf_d;
    logic signed [ACC_W-1:0] r;

    // Floor rescale: arithmetic shift drops the fractional bits toward -inf.
    function automatic logic signed [ACC_W-1:0] rescale(input logic signed [ACC_W-1:0] a);
        return a >>> frac_bits;
    endfunction

    function automatic logic out_of_range(input logic signed [ACC_W-1:0] v);
        return (v > Y_MAX) || (v < Y_MIN);
    endfunction

    function automatic logic signed [cant_bits-1:0] sat_clamp(input logic signed [ACC_W-1:0] v);
        if (v > Y_MAX) begin
            return Y_MAX[cant_bits-1:0];
        end else if (v < Y_MIN) begin
            return Y_MIN[cant_bits-1:0];
        end
        return v[cant_bits-1:0];
    endfunction
`else
    // Wrap-around output: the low cant_bits of (acc >>> frac_bits) are simply
    // acc bits [frac_bits +: cant_bits], so no wide shifter is needed.
    function automatic logic signed [cant_bits-1:0] wrap_out(input logic signed [ACC_W-1:0] a);
        return a[frac_bits +: cant_bits];
    endfunction
`endif

    // Operand select code for each MAC step (u, a, b, c, d, e).
    function automatic logic [3:0] step_code(input logic [2:0] s);
        case (s)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0101;
            3'd4:    return 4'b0110;
            3'd5:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    // Coefficient for the current step and the full-width signed product.
    always_comb begin
        case (step_q)
            3'd0:    k_sel = k_q[0];
            3'd1:    k_sel = k_q[1];
            3'd2:    k_sel = k_q[2];
            3'd3:    k_sel = k_q[3];
            3'd4:    k_sel = k_q[4];
            3'd5:    k_sel = k_q[5];
            default: k_sel = '0;
        endcase
        in_ext   = {{cant_bits{in[cant_bits-1]}}, in};
        k_ext    = {{cant_bits{k_sel[cant_bits-1]}}, k_sel};
        prod     = in_ext * k_ext;
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end

`ifdef FILTRO_SAT_EN
    // Rescaled accumulator feeding the clamp.
    always_comb begin
        r = rescale(acc_q);
    end
`endif

    // Next-state, datapath updates and operand select.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        y_d     = y_q;
        done_d  = 1'b0;
        selec   = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            k_d[i] = k_q[i];
        end
`ifdef FILTRO_SAT_EN
        ovf_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    k_d[0]  = k0;
                    k_d[1]  = k1;
                    k_d[2]  = k2;
                    k_d[3]  = k3;
                    k_d[4]  = k4;
                    k_d[5]  = k5;
                    acc_d   = '0;
                    step_d  = 3'd0;
                    state_d = MAC;
                end
            end
            MAC: begin
                selec  = step_code(step_q);
                acc_d  = acc_q + prod_ext;
                step_d = step_q + 3'd1;
                if (step_q == 3'd5) begin
                    state_d = SAT;
                end
            end
            SAT: begin
`ifdef FILTRO_SAT_EN
                y_d   = sat_clamp(r);
                ovf_d = out_of_range(r);
`else
                y_d   = wrap_out(acc_q);
`endif
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers; reset discards any computation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= 3'd0;
            acc_q   <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
`ifdef FILTRO_SAT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            done_q  <= done_d;
`ifdef FILTRO_SAT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Coefficient latch; only meaningful after a start, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            k_q[i] <= k_d[i];
        end
    end

    assign y    = y_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);
`ifdef FILTRO_SAT_EN
    assign ovf  = ovf_q;
`else
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_filtro_mac.sv
// Testbench for filtro_mac: directed vector table, randomized samples against
// an arithmetic reference model, handshake and mid-computation reset sequences.
module tb_filtro_mac;

    localparam int CB = 25;
    localparam int FB = 16;
`ifdef FILTRO_SAT_EN
    localparam int SAT_ON = 1;
`else
    localparam int SAT_ON = 0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic signed [CB-1:0] k0, k1, k2, k3, k4, k5;
    logic signed [CB-1:0] in_op;
    logic [3:0]           selec;
    logic signed [CB-1:0] y;
    logic                 done, busy, ovf;

    logic signed [CB-1:0] op [6];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Behaviour of the upstream operand mux.
    always_comb begin
        case (selec)
            4'b0000: in_op = op[0];
            4'b0001: in_op = op[1];
            4'b0010: in_op = op[2];
            4'b0101: in_op = op[3];
            4'b0110: in_op = op[4];
            4'b0111: in_op = op[5];
            default: in_op = '0;
        endcase
    end

    filtro_mac #(.cant_bits(CB), .frac_bits(FB)) dut (
        .clk(clk), .reset(reset), .start(start),
        .k0(k0), .k1(k1), .k2(k2), .k3(k3), .k4(k4), .k5(k5),
        .in(in_op), .selec(selec), .y(y), .done(done), .busy(busy), .ovf(ovf)
    );

    typedef struct packed {
        int k0, k1, k2, k3, k4, k5;
        int o0, o1, o2, o3, o4, o5;
        int ey;
        int eov;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sel_code(input int s);
        case (s)
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 5;
            4: return 6;
            5: return 7;
            default: return 15;
        endcase
    endfunction

    // Reference: exact sum of products, floor divide by 2^FB, then clamp or wrap.
    function automatic void model(input int kk[6], input int oo[6], output int ey, output int eov);
        longint acc = 0;
        longint r;
        logic signed [CB-1:0] w;
        for (int i = 0; i < 6; i++) acc += longint'(kk[i]) * longint'(oo[i]);
        r = acc >>> FB;
        if (SAT_ON != 0) begin
            if (r > 64'sd16777215) begin
                ey = 16777215; eov = 1;
            end else if (r < -64'sd16777216) begin
                ey = -16777216; eov = 1;
            end else begin
                ey = int'(r); eov = 0;
            end
        end else begin
            w = r[CB-1:0];
            ey = int'(w);
            eov = 0;
        end
    endfunction

    task automatic set_coefs(input int kk[6]);
        k0 = CB'(kk[0]); k1 = CB'(kk[1]); k2 = CB'(kk[2]);
        k3 = CB'(kk[3]); k4 = CB'(kk[4]); k5 = CB'(kk[5]);
    endtask

    // One full sample from start; starts and ends 1 time unit after a rising edge.
    task automatic run_sample(input string tag, input int kk[6], input int oo[6],
                              input int ey, input int eov);
        int cyc;
        bit got;
        logic signed [CB-1:0] y_hold;
        for (int i = 0; i < 6; i++) op[i] = CB'(oo[i]);
        set_coefs(kk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Coefficients are latched; changing them now must not matter.
        k0 = CB'($urandom); k1 = CB'($urandom); k2 = CB'($urandom);
        k3 = CB'($urandom); k4 = CB'($urandom); k5 = CB'($urandom);
        chk({tag, " busy_after_start"}, busy, 1);
        cyc = 0;
        got = 0;
        while (cyc < 20 && !got) begin
            if (cyc <= 6) chk({tag, " selec"}, selec, sel_code(cyc));
            @(posedge clk); #1;
            cyc++;
            if (done) got = 1;
        end
        chk({tag, " latency"}, got ? cyc : -1, 7);
        chk({tag, " y"}, y, ey);
        chk({tag, " ovf"}, ovf, eov);
        chk({tag, " busy_at_done"}, busy, 0);
        y_hold = y;
        @(posedge clk); #1;
        chk({tag, " done_one_cycle"}, done, 0);
        chk({tag, " y_hold"}, y, y_hold);
    endtask

    vec_t tbl [8];
    int kk [6];
    int oo [6];
    int ey, eov;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_coefs('{0, 0, 0, 0, 0, 0});
        for (int i = 0; i < 6; i++) op[i] = '0;

        // Directed vectors: k0..k5, u..e, expected y, expected ovf.
        tbl[0] = '{65536, 0, 0, 0, 0, 0, 1000, 5, 5, 5, 5, 5, 1000, 0};
        tbl[1] = '{32768, 32768, 32768, 32768, 32768, 32768,
                   100, 100, 100, 100, 100, 100, 300, 0};
        tbl[2] = '{32768, 0, 0, 0, 0, 0, -3, 0, 0, 0, 0, 0, -2, 0};
        tbl[3] = '{16777215, 16777215, 16777215, 16777215, 16777215, 16777215,
                   16777215, 16777215, 16777215, 16777215, 16777215, 16777215,
                   (SAT_ON != 0) ? 16777215 : -3072, SAT_ON};
        tbl[4] = '{16777215, 16777215, 16777215, 16777215, 16777215, 16777215,
                   -16777215, -16777215, -16777215, -16777215, -16777215, -16777215,
                   (SAT_ON != 0) ? -16777216 : 3071, SAT_ON};
        tbl[5] = '{65536, 0, 0, 0, 0, 0, 16777215, 0, 0, 0, 0, 0, 16777215, 0};
        tbl[6] = '{65536, 65536, 0, 0, 0, 0, -16777216, -1, 0, 0, 0, 0,
                   (SAT_ON != 0) ? -16777216 : 16777215, SAT_ON};
        tbl[7] = '{65536, -65536, 131072, 0, 0, -32768, 10, 3, -4, 0, 0, 8, -5, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset selec", selec, 15);
        chk("reset y", y, 0);
        chk("reset done", done, 0);
        chk("reset busy", busy, 0);
        chk("reset ovf", ovf, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            kk = '{tbl[v].k0, tbl[v].k1, tbl[v].k2, tbl[v].k3, tbl[v].k4, tbl[v].k5};
            oo = '{tbl[v].o0, tbl[v].o1, tbl[v].o2, tbl[v].o3, tbl[v].o4, tbl[v].o5};
            run_sample($sformatf("vec%0d", v), kk, oo, tbl[v].ey, tbl[v].eov);
        end

        // Randomized samples: alternate full-range and moderate magnitudes.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 6; i++) begin
                if (t % 2 == 0) begin
                    kk[i] = int'($urandom_range(33554431, 0)) - 16777216;
                    oo[i] = int'($urandom_range(33554431, 0)) - 16777216;
                end else begin
                    kk[i] = int'($urandom_range(262144, 0)) - 131072;
                    oo[i] = int'($urandom_range(2097152, 0)) - 1048576;
                end
            end
            model(kk, oo, ey, eov);
            run_sample($sformatf("rand%0d", t), kk, oo, ey, eov);
        end

        // Handshake: start held high over ten edges gives two back-to-back runs.
        begin
            int ndone = 0;
            int first = -1;
            int second = -1;
            kk = '{40000, -12345, 65536, 3, -70000, 20000};
            oo = '{1234, -5678, 999, 100000, 42, -31};
            model(kk, oo, ey, eov);
            for (int i = 0; i < 6; i++) op[i] = CB'(oo[i]);
            set_coefs(kk);
            start = 1'b1;
            for (int e = 0; e < 25; e++) begin
                @(posedge clk); #1;
                if (e == 9) start = 1'b0;
                if (done) begin
                    ndone++;
                    if (ndone == 1) first = e;
                    if (ndone == 2) second = e;
                    chk("hs y", y, ey);
                end
            end
            chk("hs done_count", ndone, 2);
            chk("hs first_done_edge", first, 7);
            chk("hs second_done_edge", second, 15);
        end

        // Nonzero y before the reset sequence.
        run_sample("pre_reset", '{65536, 0, 0, 0, 0, 0}, '{777, 0, 0, 0, 0, 0}, 777, 0);

        // Reset asserted while the MAC is at step 3.
        begin
            int seen = 0;
            kk = '{65536, 65536, 65536, 65536, 65536, 65536};
            oo = '{1, 2, 3, 4, 5, 6};
            for (int i = 0; i < 6; i++) op[i] = CB'(oo[i]);
            set_coefs(kk);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
            end
            chk("midrst selec_step3", selec, 5);
            reset = 1'b1;
            #1;
            chk("midrst selec", selec, 15);
            chk("midrst busy", busy, 0);
            chk("midrst y", y, 0);
            chk("midrst done", done, 0);
            chk("midrst ovf", ovf, 0);
            @(posedge clk); #1;
            reset = 1'b0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                if (done) seen++;
            end
            chk("midrst no_done", seen, 0);
            chk("midrst idle_busy", busy, 0);
            run_sample("post_reset", kk, oo, 21, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
